// File: rtl/spi_slv_pkg.sv
// Shared constants and state type for the SPI responder and its register file.
package spi_slv_pkg;

  localparam int FRAME_W = 16;
  localparam int CMD_W   = 8;
  localparam int RW_BIT  = 15;
  localparam int DATA_W  = 8;

  localparam int ADDR_W     = CMD_W - 1;
  localparam int CNT_W      = $clog2(FRAME_W);
  localparam int CMD_LAST   = CMD_W - 1;          // count value on the edge sampling bit 8
  localparam int FRAME_LAST = FRAME_W - 1;        // count value on the edge sampling bit 0
  localparam int RW_POS     = RW_BIT - DATA_W;    // R/W position inside the 8-bit command byte

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } spi_slv_state_e;

endpackage

// File: rtl/spi_slv_regfile.sv
// 8-bit register file: register 0 is a read-only ID, addresses >= NUM_REGS miss.
module spi_slv_regfile
  import spi_slv_pkg::*;
#(
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VAL   = 8'hA5
) (
  input  logic                     sclk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_hit,
  output logic [NUM_REGS*8-1:0]    regs
);

  // Only registers 1..NUM_REGS-1 have storage; register 0 is a constant.
  logic [DATA_W-1:0] mem [1:NUM_REGS-1];

  // Write port: an address with no matching register (0 or out of range) is dropped.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_addr == ADDR_W'(i)) mem[i] <= wr_data;
      end
    end
  end

  // Flatten the register file for the top-level output.
  always_comb begin
    regs[DATA_W-1:0] = ID_VAL;
    for (int i = 1; i < NUM_REGS; i++) regs[i*8 +: 8] = mem[i];
  end

  // Read mux: a miss returns zero and clears rd_hit.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_hit  = 1'b1;
        rd_data = regs[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/spi_slave_regs.sv
// SPI responder: 16-bit MSB-first frames {rw, addr[6:0], data[7:0]} in the sclk domain.
//
// state | meaning
// IDLE  | deselected; next selected edge samples bit 15
// CMD   | sampling command bits 15..8
// DATA  | sampling data bits 7..0, shifting read data out on miso
module spi_slave_regs
  import spi_slv_pkg::*;
#(
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VAL   = 8'hA5
) (
  input  logic                  sclk,
  input  logic                  reset,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [NUM_REGS*8-1:0] regs,
  output logic [7:0]            frame_cnt,
  output logic                  addr_err
);

  spi_slv_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-2:0] shift_q;   // the live mosi bit completes each byte
  logic [DATA_W-1:0] tx_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              cmd_done;
  logic              frame_done;
  logic [DATA_W-1:0] cur_byte;
  logic [DATA_W-1:0] rd_data;
  logic              rd_hit;

  assign cur_byte = {shift_q, mosi};

  spi_slv_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VAL   (ID_VAL)
  ) u_regfile (
    .sclk    (sclk),
    .reset   (reset),
    .wr_en   (frame_done & ~rd_q),
    .wr_addr (addr_q),
    .wr_data (cur_byte),
    .rd_addr (cur_byte[ADDR_W-1:0]),
    .rd_data (rd_data),
    .rd_hit  (rd_hit),
    .regs    (regs)
  );

  // State register.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and frame-phase strobes; deselect always wins.
  always_comb begin
    state_d    = state_q;
    cmd_done   = 1'b0;
    frame_done = 1'b0;
    if (ss_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (cnt_q == CNT_W'(CMD_LAST)) begin
            state_d  = DATA;
            cmd_done = 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_W'(FRAME_LAST)) begin
            state_d    = CMD;
            frame_done = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bit counter, shifter, command latch, miso driver, frame counter, sticky error.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      miso      <= 1'b0;
      frame_cnt <= '0;
      addr_err  <= 1'b0;
    end else if (ss_n) begin
      cnt_q <= '0;
      tx_q  <= '0;
      rd_q  <= 1'b0;
      miso  <= 1'b0;
    end else begin
      // The counter wraps 15 -> 0 so a back-to-back frame starts cleanly.
      cnt_q   <= cnt_q + 1'b1;
      shift_q <= cur_byte[DATA_W-2:0];
      if (cmd_done) begin
        addr_q <= cur_byte[ADDR_W-1:0];
        rd_q   <= cur_byte[RW_POS];
        if (!rd_hit) addr_err <= 1'b1;
        if (cur_byte[RW_POS]) begin
          miso <= rd_data[DATA_W-1];
          tx_q <= {rd_data[DATA_W-2:0], 1'b0};
        end else begin
          miso <= 1'b0;
          tx_q <= '0;
        end
      end else if (frame_done) begin
        miso      <= 1'b0;
        frame_cnt <= frame_cnt + 1'b1;
      end else if (state_q == DATA) begin
        miso <= tx_q[DATA_W-1];
        tx_q <= {tx_q[DATA_W-2:0], 1'b0};
      end else begin
        miso <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: vector table plus hand-written corner sequences.
module tb_spi_slave_regs;

  localparam int NUM_REGS = 16;

  logic                  sclk = 1'b0;
  logic                  reset;
  logic                  ss_n;
  logic                  mosi;
  logic                  miso;
  logic [NUM_REGS*8-1:0] regs;
  logic [7:0]            frame_cnt;
  logic                  addr_err;

  spi_slave_regs #(.NUM_REGS(NUM_REGS), .ID_VAL(8'hA5)) dut (
    .sclk      (sclk),
    .reset     (reset),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .regs      (regs),
    .frame_cnt (frame_cnt),
    .addr_err  (addr_err)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  exp_rd;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] model [NUM_REGS];
  logic [7:0] exp_cnt;
  logic       exp_err;
  logic [7:0] exp_q [$];
  vec_t       vecs [12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_REGS*8-1:0] model_flat();
    logic [NUM_REGS*8-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*8 +: 8] = model[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    model[0] = 8'hA5;
    exp_cnt  = 8'h00;
    exp_err  = 1'b0;
  endtask

  task automatic model_apply(input logic [15:0] f);
    int a;
    a = int'(f[14:8]);
    exp_cnt++;
    if (a >= NUM_REGS) exp_err = 1'b1;
    else if (!f[15] && a != 0) model[a] = f[7:0];
  endtask

  task automatic check_state(input string tag);
    check({tag, "_regs"},  regs, model_flat());
    check({tag, "_cnt"},   frame_cnt, exp_cnt);
    check({tag, "_err"},   addr_err, exp_err);
    check({tag, "_miso"},  miso, 1'b0);
  endtask

  // Drives nbits of f starting at bit 15 with ss_n low; collects miso from slots 8..15.
  task automatic xfer(input logic [15:0] f, input int nbits, output logic [7:0] rd);
    rd = '0;
    for (int k = 0; k < nbits; k++) begin
      @(negedge sclk);
      if (k >= 8) rd = {rd[6:0], miso};
      ss_n = 1'b0;
      mosi = f[15-k];
    end
  endtask

  task automatic deselect();
    @(negedge sclk);
    ss_n = 1'b1;
    mosi = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] rd);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0h expected <empty scoreboard>", name, rd);
    end else begin
      e = exp_q.pop_front();
      check(name, rd, e);
    end
  endtask

  // One standalone transaction: push expectation, run frame, deselect, compare.
  task automatic run_frame(input string name, input logic [15:0] f, input logic [7:0] exp_rd);
    logic [7:0] rd;
    if (f[15]) exp_q.push_back(exp_rd);
    xfer(f, 16, rd);
    deselect();
    model_apply(f);
    if (f[15]) pop_check({name, "_rd"}, rd);
    check_state(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd0, rd1;

    vecs[0]  = '{16'h8000, 8'hA5};
    vecs[1]  = '{16'h053C, 8'h00};
    vecs[2]  = '{16'h8500, 8'h3C};
    vecs[3]  = '{16'h0000, 8'h00};
    vecs[4]  = '{16'h8000, 8'hA5};
    vecs[5]  = '{16'h7F55, 8'h00};
    vecs[6]  = '{16'h9000, 8'h00};
    vecs[7]  = '{16'h0A5A, 8'h00};
    vecs[8]  = '{16'h8A00, 8'h5A};
    vecs[9]  = '{16'h8F00, 8'h00};
    vecs[10] = '{16'h0FC3, 8'h00};
    vecs[11] = '{16'h8FFF, 8'hC3};

    reset = 1'b1;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    model_reset();
    repeat (3) @(negedge sclk);
    reset = 1'b0;
    check_state("reset");

    for (int v = 0; v < 12; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].frame, vecs[v].exp_rd);
      if (v == 1) check("reg5_written", regs[47:40], 8'h3C);
    end
    check("addr_err_sticky", addr_err, 1'b1);

    // Back-to-back writes, select held for 32 edges.
    xfer(16'h0211, 16, rd0);
    xfer(16'h0322, 16, rd1);
    deselect();
    model_apply(16'h0211);
    model_apply(16'h0322);
    check("b2b_reg2", regs[23:16], 8'h11);
    check("b2b_reg3", regs[31:24], 8'h22);
    check_state("b2b_wr");

    // Write immediately followed by read of the same register.
    exp_q.push_back(8'h99);
    xfer(16'h0499, 16, rd0);
    xfer(16'h8400, 16, rd1);
    deselect();
    model_apply(16'h0499);
    model_apply(16'h8400);
    pop_check("b2b_wr_rd", rd1);
    check_state("b2b_wr_rd");

    // Deselect after 10 bits: frame discarded.
    xfer(16'h07FF, 10, rd0);
    deselect();
    check("abort_reg7", regs[63:56], 8'h00);
    check_state("abort");
    run_frame("after_abort_rd", 16'h8700, 8'h00);
    run_frame("after_abort_wr", 16'h0742, 8'h00);
    run_frame("after_abort_rd2", 16'h8700, 8'h42);

    // Reset asserted while bit 3 of a write is pending.
    xfer(16'h0677, 12, rd0);
    @(negedge sclk);
    reset = 1'b1;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    #1;
    model_reset();
    check_state("mid_reset");
    @(negedge sclk);
    reset = 1'b0;
    check_state("post_reset");
    run_frame("post_reset_rd6", 16'h8600, 8'h00);
    run_frame("post_reset_rd0", 16'h8000, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
